// File: rtl/fetch_pkg.sv
// Shared state encoding, default parameters and address legality check
// for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int          IMEM_DEPTH_DEFAULT = 2048;

    // An address is unfetchable when misaligned or past the last memory word.
    function automatic logic addr_is_bad(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: one-cycle memory latency, decode
// backpressure via memory hold, redirect flush, halt and sticky address fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_stop,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_fetch_err,
    output logic [31:0] o_fetch_cnt
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_rsp_pc;
    logic         r_rsp_valid;
    logic         r_err;
    logic [31:0]  r_cnt;

    logic w_stall;
    logic w_pc_bad;
    logic w_issue_ok;
    logic w_advance;
    logic w_fault;
    logic w_xfer;

    // Issue decision for the address currently presented to memory.
    always_comb begin
        w_stall    = r_rsp_valid && !i_instr_ready;
        w_pc_bad   = addr_is_bad(r_pc, DEPTH_W);
        w_issue_ok = (r_state == RUN) && !w_stall && !i_halt && !i_redirect;
        w_advance  = w_issue_ok && !w_pc_bad;
        w_fault    = w_issue_ok && w_pc_bad;
        w_xfer     = o_instr_valid && i_instr_ready;
    end

    // Fetch pointer, response slot and control state; redirect overrides all else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_rsp_pc    <= 32'h0000_0000;
            r_rsp_valid <= 1'b0;
            r_state     <= RUN;
            r_err       <= 1'b0;
        end else if (i_redirect) begin
            r_pc        <= i_redirect_pc;
            r_rsp_valid <= 1'b0;
            r_state     <= RUN;
            r_err       <= 1'b0;
        end else begin
            if (w_advance) begin
                r_rsp_pc    <= r_pc;
                r_rsp_valid <= 1'b1;
                r_pc        <= r_pc + 32'd4;
            end else if (w_xfer) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
            case (r_state)
                RUN: begin
                    if (i_halt) begin
                        r_state <= HALT;
                    end else if (w_fault) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                HALT, ERR: r_state <= r_state;
                default: begin
                    r_state <= ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    // Completed-transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 32'h0000_0000;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // A redirect always lets memory capture, since that cycle's data is discarded anyway.
    assign o_imem_stop   = i_redirect ? 1'b0 : !w_advance;
    assign o_imem_addr   = r_pc;
    assign o_instr       = i_imem_data;
    assign o_instr_pc    = r_rsp_pc;
    assign o_instr_valid = r_rsp_valid && !i_redirect;
    assign o_fetch_err   = r_err;
    assign o_fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus hand-written corner sequences,
// with a scoreboard of expected transferred PCs checked on every handshake.
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] o_imem_addr;
    logic        o_imem_stop;
    logic [31:0] mem_q;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_fetch_err;
    logic [31:0] o_fetch_cnt;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        rdy;
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] ipc;
        logic        stop;
        logic [31:0] addr;
        logic        err;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(
        .RESET_PC   (TB_RESET_PC),
        .IMEM_DEPTH (2048)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_imem_addr   (o_imem_addr),
        .o_imem_stop   (o_imem_stop),
        .i_imem_data   (mem_q),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_fetch_err   (o_fetch_err),
        .o_fetch_cnt   (o_fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory with mem[i] = i and an output register held by stop.
    always @(posedge clk) begin
        if (!o_imem_stop)
            mem_q <= (o_imem_addr[31:2] < 30'd2048) ? {2'b00, o_imem_addr[31:2]} : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rdy, input logic halt, input logic redir, input logic [31:0] rpc,
                       input logic valid, input logic [31:0] ipc, input logic stop,
                       input logic [31:0] addr, input logic err, input logic [31:0] cnt);
        vec_t v;
        v.rdy = rdy; v.halt = halt; v.redir = redir; v.rpc = rpc;
        v.valid = valid; v.ipc = ipc; v.stop = stop; v.addr = addr; v.err = err; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, sample at the falling edge, score any handshake.
    task automatic drive(input logic rdy, input logic halt, input logic redir,
                         input logic [31:0] rpc, input logic exp_xfer, input logic [31:0] exp_pc);
        logic [31:0] e;
        i_instr_ready = rdy;
        i_halt        = halt;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        if (exp_xfer) sb_q.push_back(exp_pc);
        @(negedge clk);
        if (o_instr_valid && i_instr_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_extra: unexpected transfer pc=%h instr=%h", o_instr_pc, o_instr);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", o_instr_pc, e);
                chk("sb_instr", o_instr, {2'b00, e[31:2]});
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        i_instr_ready = 1'b1;
        i_halt        = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;

        //   rdy halt rdr rpc            valid ipc           stop addr          err cnt
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h0,  1'b0, 32'h4,    1'b0, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h4,  1'b0, 32'h8,    1'b0, 32'd1);
        add(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h8,  1'b1, 32'hC,    1'b0, 32'd2);
        add(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h8,  1'b1, 32'hC,    1'b0, 32'd2);
        add(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h8,  1'b1, 32'hC,    1'b0, 32'd2);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h8,  1'b0, 32'hC,    1'b0, 32'd2);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'hC,  1'b0, 32'h10,   1'b0, 32'd3);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h10, 1'b0, 32'h14,   1'b0, 32'd4);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h14, 1'b0, 32'h18,   1'b0, 32'd5);
        add(1'b1, 1'b0, 1'b1, 32'h8,    1'b0, 32'h18, 1'b0, 32'h1C,   1'b0, 32'd6);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h18, 1'b0, 32'h8,    1'b0, 32'd6);
        add(1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h8,  1'b1, 32'hC,    1'b0, 32'd6);
        add(1'b0, 1'b0, 1'b1, 32'h40,   1'b0, 32'h8,  1'b0, 32'hC,    1'b0, 32'd6);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h8,  1'b0, 32'h40,   1'b0, 32'd6);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h40, 1'b0, 32'h44,   1'b0, 32'd6);
        add(1'b1, 1'b0, 1'b1, 32'h8,    1'b0, 32'h44, 1'b0, 32'h48,   1'b0, 32'd7);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h44, 1'b0, 32'h8,    1'b0, 32'd7);
        add(1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h8,  1'b1, 32'hC,    1'b0, 32'd7);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h8,  1'b1, 32'hC,    1'b0, 32'd8);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h8,  1'b1, 32'hC,    1'b0, 32'd8);
        add(1'b1, 1'b0, 1'b1, 32'h0,    1'b0, 32'h8,  1'b0, 32'hC,    1'b0, 32'd8);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h8,  1'b0, 32'h0,    1'b0, 32'd8);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h0,  1'b0, 32'h4,    1'b0, 32'd8);
        add(1'b1, 1'b0, 1'b1, 32'h2002, 1'b0, 32'h4,  1'b0, 32'h8,    1'b0, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h4,  1'b1, 32'h2002, 1'b0, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h4,  1'b1, 32'h2002, 1'b1, 32'd9);
        add(1'b1, 1'b0, 1'b1, 32'h0,    1'b0, 32'h4,  1'b0, 32'h2002, 1'b1, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h4,  1'b0, 32'h0,    1'b0, 32'd9);
        add(1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0,  1'b0, 32'h4,    1'b0, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 32'h2000, 1'b0, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 32'h2000, 1'b1, 32'd9);
        add(1'b1, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0,  1'b0, 32'h2000, 1'b1, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 32'd9);
        add(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h0,  1'b0, 32'h4,    1'b0, 32'd9);

        // Values while reset is held.
        @(negedge clk);
        chk("rst_addr",  o_imem_addr, TB_RESET_PC);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_ipc",   o_instr_pc, 32'h0);
        chk("rst_err",   {31'd0, o_fetch_err}, 32'd0);
        chk("rst_cnt",   o_fetch_cnt, 32'd0);
        chk("rst_stop",  {31'd0, o_imem_stop}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[k]) begin
            drive(vecs[k].rdy, vecs[k].halt, vecs[k].redir, vecs[k].rpc,
                  vecs[k].valid && vecs[k].rdy, vecs[k].ipc);
            chk($sformatf("v%0d_valid", k), {31'd0, o_instr_valid}, {31'd0, vecs[k].valid});
            chk($sformatf("v%0d_ipc", k),   o_instr_pc, vecs[k].ipc);
            chk($sformatf("v%0d_stop", k),  {31'd0, o_imem_stop}, {31'd0, vecs[k].stop});
            chk($sformatf("v%0d_addr", k),  o_imem_addr, vecs[k].addr);
            chk($sformatf("v%0d_err", k),   {31'd0, o_fetch_err}, {31'd0, vecs[k].err});
            chk($sformatf("v%0d_cnt", k),   o_fetch_cnt, vecs[k].cnt);
            if (vecs[k].valid) chk($sformatf("v%0d_instr", k), o_instr, {2'b00, vecs[k].ipc[31:2]});
            next_cycle();
        end

        // Last legal word is fetched, then the next address faults.
        drive(1'b1, 1'b0, 1'b1, 32'h1FFC, 1'b0, 32'h0);
        chk("lw_redir_valid", {31'd0, o_instr_valid}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("lw_addr", o_imem_addr, 32'h1FFC);
        chk("lw_stop", {31'd0, o_imem_stop}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1FFC);
        chk("lw_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("lw_instr", o_instr, 32'h7FF);
        chk("lw_fault_stop", {31'd0, o_imem_stop}, 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("lw_err", {31'd0, o_fetch_err}, 32'd1);
        chk("lw_after_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("lw_cnt", o_fetch_cnt, 32'd11);
        next_cycle();

        // Asynchronous reset in the middle of a stall at PC 8.
        drive(1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ar_stall_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("ar_stall_ipc", o_instr_pc, 32'h8);
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_addr",  o_imem_addr, TB_RESET_PC);
        chk("ar_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("ar_ipc",   o_instr_pc, 32'h0);
        chk("ar_err",   {31'd0, o_fetch_err}, 32'd0);
        chk("ar_cnt",   o_fetch_cnt, 32'd0);
        chk("ar_stop",  {31'd0, o_imem_stop}, 32'd0);
        chk("sb_drain_pre_reset", sb_q.size(), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, TB_RESET_PC);
        chk("ar_first_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("ar_first_pc", o_instr_pc, TB_RESET_PC);
        next_cycle();

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
